// File: rtl/atm_session_ctrl.sv
// Purpose : ATM card-session controller (PIN check, withdraw/deposit/inquiry, timeout, eject/retain).
// Latency : pin_valid -> error 1 cycle; op_valid -> op_done/error 2 cycles; exit -> card_eject 2 cycles.
// Backpr. : none; inputs are accepted only in their own state and ignored elsewhere.
// Ports   : clk, rst (async active-low); card_in/acct_balance start a session; pin_valid/pin_ok
//           PIN entry; op_valid/op_code/amount operation request; balance/balance_we write-back;
//           op_done/error/err_code responses; card_eject/card_retain pulses; busy = not IDLE.
module atm_session_ctrl #(
  parameter int BALANCE_WIDTH  = 20,
  parameter int MAX_PIN_TRIES  = 3,
  parameter int MAX_OP_ERRORS  = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SESSION_LIMIT  = 5000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     card_in,
  input  logic                     pin_valid,
  input  logic                     pin_ok,
  input  logic                     op_valid,
  input  logic [1:0]               op_code,
  input  logic [BALANCE_WIDTH-1:0] amount,
  input  logic [BALANCE_WIDTH-1:0] acct_balance,
  output logic [BALANCE_WIDTH-1:0] balance,
  output logic                     balance_we,
  output logic                     op_done,
  output logic                     error,
  output logic [2:0]               err_code,
  output logic                     card_eject,
  output logic                     card_retain,
  output logic                     busy
);

  localparam int BW = BALANCE_WIDTH;
  localparam int SW = BALANCE_WIDTH + 1;
  localparam int PW = $clog2(MAX_PIN_TRIES + 1);
  localparam int OW = $clog2(MAX_OP_ERRORS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] PIN_LAST = PW'(MAX_PIN_TRIES - 1);
  localparam logic [OW-1:0] OPE_LAST = OW'(MAX_OP_ERRORS - 1);
  localparam logic [TW-1:0] T_RELOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [SW-1:0] LIMIT    = SW'(SESSION_LIMIT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PIN   = 3'd1;
  localparam logic [2:0] S_MENU  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_EJECT = 3'd4;

  localparam logic [1:0] OP_WD   = 2'b00;
  localparam logic [1:0] OP_DEP  = 2'b01;
  localparam logic [1:0] OP_EXIT = 2'b11;

  localparam logic [2:0] E_PIN   = 3'b001;
  localparam logic [2:0] E_ZERO  = 3'b010;
  localparam logic [2:0] E_FUNDS = 3'b011;
  localparam logic [2:0] E_LIMIT = 3'b100;
  localparam logic [2:0] E_OVFL  = 3'b101;
  localparam logic [2:0] E_TOUT  = 3'b110;

  logic [2:0]    state;
  logic [BW-1:0] init_bal;   // balance sampled on card_in, decides write-back
  logic [1:0]    op_q;
  logic [BW-1:0] amt_q;
  logic [PW-1:0] pin_tries;
  logic [OW-1:0] op_errs;
  logic [SW-1:0] withdrawn;
  logic [TW-1:0] timer;

  // Operation evaluation for the single EXEC cycle.
  logic [SW-1:0] dep_sum;
  logic [SW-1:0] wd_sum;
  logic          ex_fail;
  logic [2:0]    ex_code;
  logic [BW-1:0] ex_bal;
  logic [SW-1:0] ex_wd;

  assign dep_sum = {1'b0, balance} + {1'b0, amt_q};
  assign wd_sum  = withdrawn + {1'b0, amt_q};

  always_comb begin
    ex_fail = 1'b0;
    ex_code = 3'b000;
    ex_bal  = balance;
    ex_wd   = withdrawn;
    case (op_q)
      OP_WD: begin
        if (amt_q == '0) begin
          ex_fail = 1'b1; ex_code = E_ZERO;
        end else if (amt_q > balance) begin
          ex_fail = 1'b1; ex_code = E_FUNDS;
        end else if (wd_sum > LIMIT) begin
          ex_fail = 1'b1; ex_code = E_LIMIT;
        end else begin
          ex_bal = balance - amt_q;
          ex_wd  = wd_sum;
        end
      end
      OP_DEP: begin
        if (amt_q == '0) begin
          ex_fail = 1'b1; ex_code = E_ZERO;
        end else if (dep_sum[BW]) begin
          ex_fail = 1'b1; ex_code = E_OVFL;
        end else begin
          ex_bal = dep_sum[BW-1:0];
        end
      end
      default: ;  // inquiry: nothing changes
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      init_bal    <= '0;
      op_q        <= '0;
      amt_q       <= '0;
      pin_tries   <= '0;
      op_errs     <= '0;
      withdrawn   <= '0;
      timer       <= '0;
      balance     <= '0;
      balance_we  <= 1'b0;
      op_done     <= 1'b0;
      error       <= 1'b0;
      err_code    <= 3'b000;
      card_eject  <= 1'b0;
      card_retain <= 1'b0;
      busy        <= 1'b0;
    end else begin
      balance_we  <= 1'b0;
      op_done     <= 1'b0;
      error       <= 1'b0;
      card_eject  <= 1'b0;
      card_retain <= 1'b0;
      case (state)
        S_IDLE: begin
          if (card_in) begin
            state     <= S_PIN;
            busy      <= 1'b1;
            balance   <= acct_balance;
            init_bal  <= acct_balance;
            pin_tries <= '0;
            op_errs   <= '0;
            withdrawn <= '0;
            timer     <= T_RELOAD;
          end
        end
        S_PIN: begin
          // Accepted input takes precedence over an expiring timer.
          if (pin_valid) begin
            timer <= T_RELOAD;
            if (pin_ok) begin
              state     <= S_MENU;
              pin_tries <= '0;
            end else begin
              error    <= 1'b1;
              err_code <= E_PIN;
              if (pin_tries == PIN_LAST) begin
                card_retain <= 1'b1;
                busy        <= 1'b0;
                state       <= S_IDLE;
                pin_tries   <= '0;
              end else begin
                pin_tries <= pin_tries + 1'b1;
              end
            end
          end else if (timer <= T_ONE) begin
            error    <= 1'b1;
            err_code <= E_TOUT;
            state    <= S_EJECT;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_MENU: begin
          if (op_valid) begin
            timer <= T_RELOAD;
            op_q  <= op_code;
            amt_q <= amount;
            state <= (op_code == OP_EXIT) ? S_EJECT : S_EXEC;
          end else if (timer <= T_ONE) begin
            error    <= 1'b1;
            err_code <= E_TOUT;
            state    <= S_EJECT;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_EXEC: begin
          balance   <= ex_bal;
          withdrawn <= ex_wd;
          timer     <= T_RELOAD;
          if (ex_fail) begin
            error    <= 1'b1;
            err_code <= ex_code;
            op_errs  <= op_errs + 1'b1;
            state    <= (op_errs == OPE_LAST) ? S_EJECT : S_MENU;
          end else begin
            op_done <= 1'b1;
            op_errs <= '0;
            state   <= S_MENU;
          end
        end
        S_EJECT: begin
          card_eject <= 1'b1;
          balance_we <= (balance != init_bal);
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
